// File: rtl/av2_recon_writeback.sv
// av2_recon_writeback
//   Buffers 128-bit reconstruction beats from the AV2 tile decoder in a small
//   FIFO, coalesces address-contiguous beats into bursts and writes them to
//   frame memory over a request/grant + valid/ready port. frame_done pulses
//   once a tile has ended and every accepted beat has been written.
//
//   Optional feature: define AV2_WB_CHECKSUM_EN to enable the byte checksum
//   of written data; when undefined, checksum is tied to 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   frame_base      byte base of the frame buffer (sampled on push)
//   recon_data      16 pixels, byte k = pixel k
//   recon_addr      pixel index of byte 0 (multiple of 16)
//   recon_wr_en     beat present this cycle (no backpressure)
//   tile_done       one-cycle end-of-tile pulse
//   mem_req/mem_gnt burst request handshake, mem_addr/mem_len burst descriptor
//   mem_wdata/mem_wvalid/mem_wready/mem_wlast   write data channel
//   frame_done      one-cycle completion pulse
//   overflow        sticky: a beat was dropped because the FIFO was full
//   fifo_level      current FIFO occupancy
//   checksum        byte checksum of written data (0 without the macro)
module av2_recon_writeback #(
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        frame_base,
    input  logic [127:0]       recon_data,
    input  logic [31:0]        recon_addr,
    input  logic               recon_wr_en,
    input  logic               tile_done,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    output logic [7:0]         mem_len,
    input  logic               mem_gnt,
    output logic [127:0]       mem_wdata,
    output logic               mem_wvalid,
    input  logic               mem_wready,
    output logic               mem_wlast,
    output logic               frame_done,
    output logic               overflow,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [31:0]        checksum
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t                 state;
    logic [127:0]           fifo_data [FIFO_DEPTH];
    logic [31:0]            fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_cont;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [31:0]            last_recon_addr;
    logic [31:0]            last_byte_addr;
    logic                   dup_armed;
    logic                   have_prev;
    logic                   flush_pending;
    logic [7:0]             beat_cnt;

    logic [31:0]            byte_addr;
    logic                   is_dup;
    logic                   is_full;
    logic                   push;
    logic                   drop;
    logic                   pop;
    logic [LVL_W-1:0]       run_len;
    logic                   run_open;
    logic                   start_burst;

    assign byte_addr  = frame_base + recon_addr;
    assign is_dup     = recon_wr_en && dup_armed && (recon_addr == last_recon_addr);
    // A pop in the same cycle does not make room for an incoming beat.
    assign is_full    = (level == LVL_W'(FIFO_DEPTH));
    assign push       = recon_wr_en && !is_dup && !is_full;
    assign drop       = recon_wr_en && !is_dup && is_full;
    assign pop        = mem_wvalid && mem_wready;
    assign fifo_level = level;
    assign mem_wlast  = mem_wvalid && (beat_cnt == mem_len - 8'd1);
    assign mem_wdata  = mem_wvalid ? fifo_data[rd_ptr] : '0;

    // Run = head plus following entries flagged contiguous, capped at
    // BURST_LEN. The head's own cont flag is irrelevant: a run always starts
    // at the head.
    always_comb begin
        run_len  = '0;
        run_open = 1'b1;
        for (int i = 0; i < BURST_LEN; i++) begin
            if (run_open && (LVL_W'(i) < level) &&
                (i == 0 || fifo_cont[rd_ptr + PTR_W'(i)])) begin
                run_len = run_len + LVL_W'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

    // level > run_len with run_len < BURST_LEN means the entry right behind
    // the run exists and broke contiguity, so the run can never grow.
    assign start_burst = (run_len == LVL_W'(BURST_LEN)) ||
                         (level > run_len) ||
                         (flush_pending && (level != '0));

    // FIFO payload storage: written on push only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= recon_data;
            fifo_addr[wr_ptr] <= byte_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            mem_len         <= '0;
            mem_wvalid      <= 1'b0;
            frame_done      <= 1'b0;
            overflow        <= 1'b0;
            beat_cnt        <= '0;
            flush_pending   <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            fifo_cont       <= '0;
            last_recon_addr <= '0;
            last_byte_addr  <= '0;
            dup_armed       <= 1'b0;
            have_prev       <= 1'b0;
        end else begin
            if (push) begin
                fifo_cont[wr_ptr] <= have_prev && (byte_addr == last_byte_addr + 32'd16);
                wr_ptr            <= wr_ptr + PTR_W'(1);
                last_byte_addr    <= byte_addr;
                last_recon_addr   <= recon_addr;
                have_prev         <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // A tile_done arriving in DONE starts a new pending flush.
            if (tile_done) begin
                flush_pending <= 1'b1;
            end else if (state == DONE) begin
                flush_pending <= 1'b0;
            end

            if (push) begin
                dup_armed <= 1'b1;
            end else if (state == DONE) begin
                dup_armed <= 1'b0;
            end

            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_burst) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fifo_addr[rd_ptr];
                        mem_len  <= 8'(run_len);
                    end else if (flush_pending && (level == '0)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state      <= DATA;
                        mem_req    <= 1'b0;
                        mem_wvalid <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (pop) begin
                        if (mem_wlast) begin
                            state      <= IDLE;
                            mem_wvalid <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AV2_WB_CHECKSUM_EN
    logic [31:0] cksum;

    function automatic logic [31:0] byte_sum(input logic [127:0] d);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) begin
            s = s + {24'd0, d[8*k +: 8]};
        end
        return s;
    endfunction

    // Holds through the frame_done cycle, clears on the one after.
    always_ff @(posedge clk) begin
        if (rst) begin
            cksum <= '0;
        end else if (frame_done) begin
            cksum <= '0;
        end else if (pop) begin
            cksum <= cksum + byte_sum(mem_wdata);
        end
    end

    assign checksum = cksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_av2_recon_writeback.sv
module tb_av2_recon_writeback;

    localparam int FIFO_DEPTH = 8;
    localparam int BURST_LEN  = 4;
    localparam int LVL_W      = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  frame_base = '0;
    logic [127:0] recon_data = '0;
    logic [31:0]  recon_addr = '0;
    logic         recon_wr_en = 1'b0;
    logic         tile_done = 1'b0;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [7:0]   mem_len;
    logic         mem_gnt = 1'b0;
    logic [127:0] mem_wdata;
    logic         mem_wvalid;
    logic         mem_wready = 1'b0;
    logic         mem_wlast;
    logic         frame_done;
    logic         overflow;
    logic [LVL_W-1:0] fifo_level;
    logic [31:0]  checksum;

    av2_recon_writeback #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .BURST_LEN (BURST_LEN),
        .LVL_W     (LVL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_base (frame_base),
        .recon_data (recon_data),
        .recon_addr (recon_addr),
        .recon_wr_en(recon_wr_en),
        .tile_done  (tile_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_gnt    (mem_gnt),
        .mem_wdata  (mem_wdata),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_wlast  (mem_wlast),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory-side responder: 0 = always 1, 1 = random, 2 = held 0.
    int gnt_mode = 0;
    int rdy_mode = 0;
    bit pat_on   = 1'b0;
    bit pat[$];
    int pidx     = 0;

    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = ($urandom_range(0, 3) != 0);
            default: mem_gnt = 1'b0;
        endcase
        if (pat_on) begin
            mem_wready = (pidx < pat.size()) ? pat[pidx] : 1'b1;
            if (mem_wvalid) pidx++;
        end else begin
            mem_wready = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: reconstructs the written stream from the bus.
    logic [31:0]  g_addr[$];
    logic [127:0] g_data[$];
    logic [31:0]  b_addr[$];
    int           b_len[$];
    int           wlast_err = 0;
    int           stall_err = 0;
    int           done_n    = 0;
    int           cyc_n     = 0;
    int           last_hs_cyc = 0;
    int           done_cyc  = 0;
    logic [31:0]  done_ck   = '0;
    logic [31:0]  cur_addr  = '0;
    int           cur_len   = 0;
    int           bidx      = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            prev_stall = 1'b0;
            bidx       = 0;
        end else begin
            if (prev_stall && mem_wvalid &&
                (mem_wdata !== prev_data || mem_wlast !== prev_last)) stall_err++;
            if (mem_req && mem_gnt) begin
                b_addr.push_back(mem_addr);
                b_len.push_back(int'(mem_len));
                cur_addr = mem_addr;
                cur_len  = int'(mem_len);
                bidx     = 0;
            end
            if (mem_wvalid && mem_wready) begin
                g_addr.push_back(cur_addr + 32'(bidx * 16));
                g_data.push_back(mem_wdata);
                if (mem_wlast !== (bidx == cur_len - 1)) wlast_err++;
                bidx++;
                last_hs_cyc = cyc_n;
            end
            prev_stall = mem_wvalid && !mem_wready;
            prev_data  = mem_wdata;
            prev_last  = mem_wlast;
            if (frame_done) begin
                done_n++;
                done_cyc = cyc_n;
                done_ck  = checksum;
            end
        end
    end

    // Reference model: ordered list of writes the memory should receive.
    logic [31:0]  e_addr[$];
    logic [127:0] e_data[$];
    bit           m_armed = 1'b0;
    logic [31:0]  m_last  = '0;
    logic [31:0]  base    = '0;

    task automatic model_push(input logic [31:0] a, input logic [127:0] d);
        if (m_armed && a == m_last) return;
        m_armed = 1'b1;
        m_last  = a;
        e_addr.push_back(base + a);
        e_data.push_back(d);
    endtask

    function automatic logic [31:0] exp_cksum();
        logic [31:0] s;
        s = '0;
`ifdef AV2_WB_CHECKSUM_EN
        foreach (e_data[i])
            for (int k = 0; k < 16; k++) s = s + 32'(e_data[i][8*k +: 8]);
`endif
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [127:0] d, input bit tl);
        recon_addr  = a;
        recon_data  = d;
        frame_base  = base;
        recon_wr_en = 1'b1;
        tile_done   = tl;
        cyc();
        recon_wr_en = 1'b0;
        tile_done   = 1'b0;
    endtask

    task automatic pulse_tile();
        tile_done = 1'b1;
        cyc();
        tile_done = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        for (int i = 0; i < 3000 && done_n < target; i++) cyc();
        ok = (done_n >= target);
    endtask

    task automatic clear_all();
        g_addr.delete(); g_data.delete(); b_addr.delete(); b_len.delete();
        e_addr.delete(); e_data.delete();
        wlast_err = 0; stall_err = 0; done_n = 0;
        m_armed = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; recon_wr_en = 1'b0; tile_done = 1'b0;
        gnt_mode = 0; rdy_mode = 0; pat_on = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        clear_all();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_tests++;
        if ({mem_req, mem_wvalid, mem_wlast, frame_done, overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {mem_req, mem_wvalid, mem_wlast, frame_done, overflow});
        end
        n_tests++;
        if (fifo_level !== '0 || checksum !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_level_cksum: got level %0d cksum %0h expected 0 0", fifo_level, checksum);
        end
        n_tests++;
        if (mem_addr !== 32'd0 || mem_len !== 8'd0 || mem_wdata !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %0h len %0d data %0h expected 0", mem_addr, mem_len, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_burst4();
        bit ok;
        logic [127:0] d;
        apply_reset();
        base = 32'h1000;
        d = {16{8'h01}};
        for (int i = 0; i < 4; i++) begin
            send(32'(i * 16), d, 1'b0);
            model_push(32'(i * 16), d);
        end
        pulse_tile();
        wait_done(1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL burst4_done: got no frame_done expected one"); end
        n_tests++;
        if (b_addr.size() != 1 || b_addr[0] !== 32'h1000 || b_len[0] != 4) begin
            n_fail++;
            $display("FAIL burst4_desc: got %0d bursts first addr %0h len %0d expected 1 burst 1000 len 4",
                     b_addr.size(), (b_addr.size() > 0) ? b_addr[0] : 32'hx, (b_len.size() > 0) ? b_len[0] : -1);
        end
        n_tests++;
        if (g_data.size() != e_data.size() || g_data != e_data || g_addr != e_addr) begin
            n_fail++;
            $display("FAIL burst4_stream: got %0d beats expected %0d matching beats", g_data.size(), e_data.size());
        end
        n_tests++;
        if (wlast_err != 0) begin n_fail++; $display("FAIL burst4_wlast: got %0d misplaced wlast expected 0", wlast_err); end
        n_tests++;
        if (done_ck !== exp_cksum()) begin
            n_fail++;
            $display("FAIL burst4_cksum: got %0h expected %0h", done_ck, exp_cksum());
        end
        cyc(); cyc();
        n_tests++;
        if (checksum !== 32'd0) begin n_fail++; $display("FAIL burst4_cksum_clear: got %0h expected 0", checksum); end
    endtask

    task automatic test_split();
        bit ok;
        logic [127:0] d;
        apply_reset();
        base = 32'h1000;
        foreach (b_len[i]) ;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = (i == 2) ? 32'd64 : 32'(i * 16);
            d = rnd128();
            send(a, d, 1'b0);
            model_push(a, d);
        end
        pulse_tile();
        wait_done(1, ok);
        cyc(); cyc(); cyc();
        n_tests++;
        if (b_addr.size() != 2 || b_addr[0] !== 32'h1000 || b_len[0] != 2 ||
            b_addr[1] !== 32'h1040 || b_len[1] != 1) begin
            n_fail++;
            $display("FAIL split_desc: got %0d bursts expected {1000,2},{1040,1}", b_addr.size());
        end
        n_tests++;
        if (g_data != e_data || g_addr != e_addr) begin
            n_fail++;
            $display("FAIL split_stream: got %0d beats expected %0d", g_data.size(), e_data.size());
        end
        n_tests++;
        if (done_n != 1 || done_cyc - last_hs_cyc != 2) begin
            n_fail++;
            $display("FAIL split_done: got %0d pulses at +%0d cycles expected 1 at +2", done_n, done_cyc - last_hs_cyc);
        end
    endtask

    task automatic test_dup();
        bit ok;
        logic [127:0] d;
        apply_reset();
        base = $urandom & 32'hFFFF_FFF0;
        d = rnd128();
        send(32'd48, d, 1'b0); model_push(32'd48, d);
        send(32'd48, d, 1'b0); model_push(32'd48, d);
        pulse_tile();
        wait_done(1, ok);
        n_tests++;
        if (g_data.size() != 1 || g_data != e_data || g_addr != e_addr) begin
            n_fail++;
            $display("FAIL dup_single: got %0d beats expected 1", g_data.size());
        end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL dup_overflow: got %b expected 0", overflow); end
        // The filter is disarmed by frame_done: the same address writes again.
        m_armed = 1'b0;
        send(32'd48, d, 1'b0); model_push(32'd48, d);
        pulse_tile();
        wait_done(2, ok);
        n_tests++;
        if (!ok || g_data.size() != 2 || g_data != e_data) begin
            n_fail++;
            $display("FAIL dup_rearm: got %0d beats expected 2", g_data.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [127:0] d;
        apply_reset();
        base = 32'h2000;
        gnt_mode = 2;
        for (int i = 0; i < 9; i++) begin
            d = rnd128();
            send(32'(i * 16), d, 1'b0);
            if (i < FIFO_DEPTH) model_push(32'(i * 16), d);
        end
        cyc(); cyc();
        n_tests++;
        if (fifo_level !== LVL_W'(FIFO_DEPTH) || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: got level %0d overflow %b expected 8 1", fifo_level, overflow);
        end
        gnt_mode = 0;
        pulse_tile();
        wait_done(1, ok);
        n_tests++;
        if (!ok || g_data.size() != FIFO_DEPTH || g_data != e_data || g_addr != e_addr) begin
            n_fail++;
            $display("FAIL ovf_stream: got %0d beats expected %0d", g_data.size(), FIFO_DEPTH);
        end
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [127:0] d;
        apply_reset();
        base = 32'h0004_0000;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        pidx = 0;
        pat_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = rnd128();
            send(32'(256 + i * 16), d, 1'b0);
            model_push(32'(256 + i * 16), d);
        end
        pulse_tile();
        wait_done(1, ok);
        pat_on = 1'b0;
        n_tests++;
        if (!ok || g_data != e_data || g_addr != e_addr) begin
            n_fail++;
            $display("FAIL stall_stream: got %0d beats expected %0d", g_data.size(), e_data.size());
        end
        n_tests++;
        if (stall_err != 0 || wlast_err != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d unstable %0d wlast errors expected 0 0", stall_err, wlast_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [127:0] d;
        apply_reset();
        base = 32'h3000;
        for (int i = 0; i < 4; i++) send(32'(i * 16), rnd128(), 1'b0);
        for (int i = 0; i < 50 && !mem_wvalid; i++) cyc();
        n_tests++;
        if (mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_start: got wvalid %b expected 1", mem_wvalid); end
        cyc();
        rst = 1'b1;
        cyc();
        n_tests++;
        if ({mem_wvalid, mem_wlast, mem_req, frame_done, overflow} !== 5'b0 ||
            fifo_level !== '0 || mem_wdata !== 128'd0 || checksum !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_zero: got ctrl %b level %0d expected all 0",
                     {mem_wvalid, mem_wlast, mem_req, frame_done, overflow}, fifo_level);
        end
        rst = 1'b0;
        clear_all();
        d = rnd128();
        send(32'd0, d, 1'b0); model_push(32'd0, d);
        pulse_tile();
        wait_done(1, ok);
        n_tests++;
        if (!ok || b_addr.size() != 1 || b_addr[0] !== 32'h3000 || b_len[0] != 1 ||
            g_data != e_data) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got %0d bursts %0d beats expected 1 burst len 1", b_addr.size(), g_data.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        bit len_bad;
        logic [127:0] d;
        logic [31:0]  a;
        apply_reset();
        base = $urandom & 32'hFFFF_FFF0;
        a = 32'hFFFF_FF80;
        gnt_mode = 1;
        rdy_mode = 1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0 && fifo_level <= 5) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6)      a = a + 32'd16;
                else if (r == 9) a = $urandom & 32'hFFFF_FFF0;
                d = rnd128();
                send(a, d, 1'b0);
                model_push(a, d);
            end else begin
                cyc();
            end
        end
        pulse_tile();
        wait_done(1, ok);
        n_tests++;
        if (!ok || g_data != e_data || g_addr != e_addr) begin
            n_fail++;
            $display("FAIL rand_stream: got %0d beats expected %0d", g_data.size(), e_data.size());
        end
        len_bad = 1'b0;
        foreach (b_len[i]) if (b_len[i] < 1 || b_len[i] > BURST_LEN) len_bad = 1'b1;
        n_tests++;
        if (len_bad || overflow !== 1'b0 || wlast_err != 0 || stall_err != 0) begin
            n_fail++;
            $display("FAIL rand_proto: got lenbad %b ovf %b wlast %0d stall %0d expected 0 0 0 0",
                     len_bad, overflow, wlast_err, stall_err);
        end
        n_tests++;
        if (done_ck !== exp_cksum()) begin
            n_fail++;
            $display("FAIL rand_cksum: got %0h expected %0h", done_ck, exp_cksum());
        end
    endtask

    initial begin
        test_reset();
        test_burst4();
        test_split();
        test_dup();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/av2_recon_writeback.md
# av2_recon_writeback

Downstream of the AV2 tile decoder: takes its 16-pixel, 128-bit reconstruction beats, which arrive with no backpressure. Buffers them in a small FIFO, coalesces contiguous beats into bursts, and writes them to frame memory through a request/grant plus valid/ready write port. Signals `frame_done` once the tile has ended and every accepted beat has been written.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: FIFO entries (data + address); power of two, at least 2.
- `BURST_LEN`, 4: maximum beats per memory burst; at least 1 and at most `FIFO_DEPTH`.
- `LVL_W`, $clog2(FIFO_DEPTH)+1: width of the FIFO level output.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `frame_base` in 32: byte base address of the frame buffer; sampled when a beat is pushed.
- `recon_data` in 128: 16 pixels, byte k holds pixel k.
- `recon_addr` in 32: pixel index of byte 0; always a multiple of 16.
- `recon_wr_en` in 1: a beat is present this cycle.
- `tile_done` in 1: one-cycle pulse marking end of tile.
- `mem_req` out 1: burst request.
- `mem_addr` out 32: burst start byte address.
- `mem_len` out 8: beats in the burst, 1..`BURST_LEN`.
- `mem_gnt` in 1: request accepted.
- `mem_wdata` out 128: write data.
- `mem_wvalid` out 1: write beat valid.
- `mem_wready` in 1: write beat accepted.
- `mem_wlast` out 1: final beat of the burst.
- `frame_done` out 1: one-cycle completion pulse.
- `overflow` out 1: sticky flag; a beat was dropped because the FIFO was full.
- `fifo_level` out `LVL_W`: current FIFO occupancy.
- `checksum` out 32: byte checksum of written data (see Configuration).

## Operation
- **Push.**
  - A beat with `recon_wr_en`=1 is pushed as {data, `frame_base`+`recon_addr`, cont}.
  - cont=1 when the byte address equals the previous pushed address plus 16.
- **Duplicate filter.** A beat whose `recon_addr` equals the last pushed `recon_addr` is discarded; it is not pushed and does not set `overflow`. The filter is disarmed after reset and after `frame_done`.
- **Full.** A non-duplicate beat arriving with the FIFO full (level = `FIFO_DEPTH`, pop in the same cycle ignored) is dropped and sets `overflow`=1 until `rst`.
- **Run.** The run is the head entry plus the following entries with cont=1, capped at `BURST_LEN`.
- **Flush flag.** `tile_done` sets flush_pending.
- State machine:
  - IDLE → REQ when one of these holds:
    - the run equals `BURST_LEN`;
    - an entry with cont=0 exists behind the run;
    - flush_pending=1 and the FIFO is non-empty.
  - Entering REQ latches `mem_addr` = head address and `mem_len` = run length.
  - IDLE → DONE when flush_pending=1 and the FIFO is empty.
  - REQ: `mem_req`=1, with `mem_addr` and `mem_len` stable. On `mem_gnt` → DATA.
  - DATA:
    - `mem_wvalid`=1 and `mem_wdata` = head data.
    - Pop on `mem_wvalid`&`mem_wready`.
    - `mem_wlast`=1 on beat `mem_len`-1.
    - The pop with `mem_wlast` → IDLE.
  - DONE:
    - `frame_done`=1 for one cycle.
    - Clear flush_pending and disarm the duplicate filter.
    - → IDLE.
- **Simultaneous events.**
  - `tile_done` with `recon_wr_en` in the same cycle: the beat is pushed, and it is written before `frame_done`.
  - A push and a pop in the same cycle leave the level unchanged.
  - A `tile_done` arriving while not in IDLE stays pending.
- **Wrap-around.** FIFO pointers wrap modulo `FIFO_DEPTH`. Address arithmetic is modulo 2^32.

## Timing
- **Reset values.** Every output is 0 after the `rst` edge. State, FIFO, flags and checksum are cleared.
- **Reset mid-burst.** The burst is abandoned: no `mem_wlast` is issued and `mem_wvalid` drops on the next edge.
- **Push visibility.** A pushed beat is visible in `fifo_level` on the next cycle.
- **Minimum latency.** With `BURST_LEN`=1 and immediate `mem_gnt`/`mem_wready`, push to the first `mem_wvalid` takes 3 cycles: push, IDLE→REQ, REQ with gnt → DATA.
- **Burst rate.** Within a burst, one beat per cycle while `mem_wready`=1. Back-to-back bursts have one IDLE cycle between them.
- **Done.** `frame_done` asserts 2 cycles after the final `mem_wlast` handshake when flush_pending is set; it asserts 2 cycles after `tile_done` when the FIFO was already empty.
- **Stability.** `mem_wdata` and `mem_wlast` are stable while `mem_wvalid`=1 and `mem_wready`=0.

## Configuration
- `AV2_WB_CHECKSUM_EN` defined:
  - `checksum` accumulates, modulo 2^32, the sum of all 16 bytes of each accepted write beat (`mem_wvalid`&`mem_wready`).
  - It holds its value through the `frame_done` cycle and clears on the following cycle.
- `AV2_WB_CHECKSUM_EN` undefined: `checksum` is tied to 0 and no accumulator logic is present. The port exists in both builds.

## Test plan
- Four beats at addr 0,16,32,48 (data bytes = 0x01), `frame_base`=0x1000, gnt/wready tied 1 → one burst, `mem_addr`=0x1000, `mem_len`=4, `mem_wlast` on beat 4; checksum=64 with macro.
- Beats at 0,16,64 then `tile_done` → bursts {0x1000, len 2} and {0x1040, len 1}; `frame_done` pulses once after the second `mem_wlast`.
- Beat 48 repeated on two consecutive cycles → a single entry is written; `overflow` stays 0.
- `mem_gnt` held 0 while 9 distinct beats arrive (depth 8) → `fifo_level`=8, `overflow`=1; after release exactly 8 beats are written.
- `mem_wready` toggling 1,0,0,1 within a burst → `mem_wdata` holds during stalls; no beat is lost or repeated.
- `rst` asserted during beat 2 of a 4-beat burst → all outputs 0 next cycle; a fresh single beat afterwards writes correctly with `mem_len`=1 after `tile_done`.
